// File: rtl/div_16bit.sv
// div_16bit: sequential unsigned restoring divider.
// One quotient bit per clock in RUN; results appear registered in DONE.
// A zero divisor skips iteration and reports div_by_zero with all-ones quotient.
module div_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs;        // captured divisor
    logic [WIDTH-1:0] prem;       // partial remainder, always < dvs
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] dvd_next;

    // One restoring step: shift in next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted   = {prem, dvd[WIDTH-1]};
        // The trial difference is one bit wider than the operands so a divisor
        // of 16'h8000 or more cannot lose its carry. Because prem < dvs,
        // shifted < 2*dvs, so the top bit of diff is exactly the borrow.
        diff      = shifted - {1'b0, dvs};
        fits      = ~diff[WIDTH];
        prem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_next  = {dvd[WIDTH-2:0], fits};
    end

    // Control FSM, datapath registers and registered outputs.
    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // every state element, datapath included, is cleared with <= like any
    // other sequential update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            cnt         <= '0;
            Quot        <= '0;
            Rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd         <= A;
                        dvs         <= B;
                        prem        <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        if (B == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            Quot        <= '1;
                            Rem         <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd  <= dvd_next;
                    prem <= prem_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Quot  <= dvd_next;
                        Rem   <= prem_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_16bit.sv
// tb_div_16bit: directed checks of div_16bit latency, results, zero divisor,
// start-while-running, mid-run reset and back-to-back operation.
module tb_div_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Quot;
    logic [15:0] Rem;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    div_16bit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Quot        (Quot),
        .Rem         (Rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation: accept on the next edge, then watch until done.
    // Operands are scrambled right after the accept; poke re-asserts start mid-run.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit poke);
        int          cyc      = 0;
        int          busy_cyc = 0;
        int          extra    = 0;
        logic [15:0] eq;
        logic [15:0] er;
        eq = (b == 16'd0) ? 16'hFFFF : a / b;
        er = (b == 16'd0) ? a : a % b;
        @(negedge clk);
        rst_n = 1'b1;
        A     = a;
        B     = b;
        start = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                A     = ~a;
                B     = b + 16'd3;
            end
            if (poke && cyc == 3) begin
                start = 1'b1;
                A     = 16'd50;
                B     = 16'd5;
            end
            if (poke && cyc == 5) start = 1'b0;
            if (busy) busy_cyc++;
        end while (!done && cyc < 40);
        check($sformatf("latency %0d/%0d", a, b), cyc, (b == 16'd0) ? 1 : 17);
        check($sformatf("busy_cycles %0d/%0d", a, b), busy_cyc, (b == 16'd0) ? 0 : 16);
        check($sformatf("quot %0d/%0d", a, b), Quot, eq);
        check($sformatf("rem %0d/%0d", a, b), Rem, er);
        check($sformatf("dbz %0d/%0d", a, b), div_by_zero, (b == 16'd0) ? 1 : 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check($sformatf("extra_done %0d/%0d", a, b), extra, 0);
        check($sformatf("quot_hold %0d/%0d", a, b), Quot, eq);
        check($sformatf("dbz_hold %0d/%0d", a, b), div_by_zero, (b == 16'd0) ? 1 : 0);
    endtask

    logic [15:0] ra [20];
    logic [15:0] rb [20];

    initial begin
        int n;
        int last;
        int dcnt;

        // Reset with start held high: must be ignored while rst_n is low.
        rst_n = 1'b0;
        start = 1'b1;
        A     = 16'd100;
        B     = 16'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_quot", Quot, 16'd0);
        check("reset_rem", Rem, 16'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_dbz", div_by_zero, 1'b0);

        // First accept on the first edge after reset release.
        run_op(16'd100, 16'd7, 1'b0);
        run_op(16'hFFFF, 16'd1, 1'b0);
        run_op(16'hFFFF, 16'h8000, 1'b0);
        run_op(16'd5, 16'd0, 1'b0);
        run_op(16'd3, 16'd10, 1'b1);
        run_op(16'd0, 16'd9, 1'b0);
        run_op(16'd7, 16'd7, 1'b0);
        run_op(16'h8000, 16'hFFFF, 1'b0);

        // Reset in the 8th RUN cycle aborts with no done and clears results.
        @(negedge clk);
        A     = 16'd1000;
        B     = 16'd3;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_quot", Quot, 16'd0);
        check("abort_rem", Rem, 16'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_dbz", div_by_zero, 1'b0);
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_quot_hold", Quot, 16'd0);
        run_op(16'd9, 16'd4, 1'b0);

        // Back-to-back operations with start held high.
        for (int i = 0; i < 20; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            if (rb[i] == 16'd0) rb[i] = 16'd1;
        end
        rb[3] = 16'h8001;
        rb[7] = 16'd1;
        ra[9] = 16'd2;
        rb[9] = 16'd900;
        @(negedge clk);
        A     = ra[0];
        B     = rb[0];
        start = 1'b1;
        last  = -1;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            check($sformatf("b2b_done_%0d", i), done, 1'b1);
            check($sformatf("b2b_quot_%0d", i), Quot, ra[i] / rb[i]);
            check($sformatf("b2b_rem_%0d", i), Rem, ra[i] % rb[i]);
            if (last >= 0) check($sformatf("b2b_spacing_%0d", i), cycle - last, 18);
            last = cycle;
            if (i < 19) begin
                A = ra[i+1];
                B = rb[i+1];
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
